// File: rtl/pic_cycle_ctrl_if.sv
// pic_cycle_ctrl_if: bundle between the PIC16F54 cycle sequencer and its neighbours.
//   Decoded controls (sleep_i, clrwdt_i, branch_i, skip_i) and the watchdog
//   overflow (wdt_tmo) flow into the sequencer. Phase count (q), fetch/commit
//   strobes, NOP select, sleep status, watchdog pulses and STATUS TO/PD flow out.
//   slave  : the sequencer side.
//   master : the decoder/datapath side.
interface pic_cycle_ctrl_if #(
  parameter int unsigned QW = 2
);
  logic          sleep_i;
  logic          clrwdt_i;
  logic          branch_i;
  logic          skip_i;
  logic          wdt_tmo;
  logic [QW-1:0] q;
  logic          fetch_en;
  logic          exec_en;
  logic          nop_sel;
  logic          sleeping;
  logic          wdt_clr;
  logic          wdt_rst;
  logic          to_n;
  logic          pd_n;

  modport slave (
    input  sleep_i, clrwdt_i, branch_i, skip_i, wdt_tmo,
    output q, fetch_en, exec_en, nop_sel, sleeping, wdt_clr, wdt_rst, to_n, pd_n
  );

  modport master (
    output sleep_i, clrwdt_i, branch_i, skip_i, wdt_tmo,
    input  q, fetch_en, exec_en, nop_sel, sleeping, wdt_clr, wdt_rst, to_n, pd_n
  );
endinterface

// File: rtl/pic_cycle_ctrl.sv
// pic_cycle_ctrl: instruction-cycle sequencer for the PIC16F54 core.
//   Produces the Q-phase count, per-cycle fetch/commit strobes, a one-cycle
//   NOP flush after taken branches/skips, and SLEEP / watchdog wake-up
//   sequencing with the STATUS TO/PD flags.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset
//   bus  - pic_cycle_ctrl_if.slave (decoded controls in, strobes/status out)
module pic_cycle_ctrl #(
  parameter int unsigned QW = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  pic_cycle_ctrl_if.slave      bus
);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    SLEEP = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [QW-1:0] q_q, q_d;
  logic          to_n_q, to_n_d;
  logic          pd_n_q, pd_n_d;
  logic          q4;
  logic          fetch, exec, wclr, wrst;

  assign q4 = (q_q == '1);

  always_comb begin
    state_d = state_q;
    q_d     = q_q + QW'(1);
    to_n_d  = to_n_q;
    pd_n_d  = pd_n_q;
    fetch   = 1'b0;
    exec    = 1'b0;
    wclr    = 1'b0;
    wrst    = 1'b0;

    if (bus.wdt_tmo) begin
      // Timeout overrides every decoded input; a wake from SLEEP keeps PD low.
      wrst    = 1'b1;
      state_d = FILL;
      q_d     = '0;
      to_n_d  = 1'b0;
      if (state_q != SLEEP) pd_n_d = 1'b1;
    end else begin
      unique case (state_q)
        FILL: begin
          fetch = q4;
          if (q4) state_d = RUN;
        end
        RUN: begin
          if (q4) begin
            fetch = 1'b1;
            exec  = 1'b1;
            if (bus.branch_i || bus.skip_i) begin
              state_d = FLUSH;
            end else if (bus.sleep_i) begin
              wclr    = 1'b1;
              pd_n_d  = 1'b0;
              to_n_d  = 1'b1;
              state_d = SLEEP;
            end else if (bus.clrwdt_i) begin
              wclr   = 1'b1;
              to_n_d = 1'b1;
              pd_n_d = 1'b1;
            end
          end
        end
        FLUSH: begin
          fetch = q4;
          if (q4) state_d = RUN;
        end
        SLEEP: begin
          q_d = '0;
        end
        default: begin
          state_d = FILL;
          q_d     = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      q_q     <= '0;
      to_n_q  <= 1'b1;
      pd_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      to_n_q  <= to_n_d;
      pd_n_q  <= pd_n_d;
    end
  end

  // Outputs are forced to reset values while rst is high so they are
  // defined even before the first reset edge has loaded the registers.
  assign bus.q        = rst ? '0 : q_q;
  assign bus.fetch_en = fetch & ~rst;
  assign bus.exec_en  = exec  & ~rst;
  assign bus.wdt_clr  = wclr  & ~rst;
  assign bus.wdt_rst  = wrst  & ~rst;
  assign bus.nop_sel  = rst | (state_q != RUN);
  assign bus.sleeping = ~rst & (state_q == SLEEP);
  assign bus.to_n     = rst | to_n_q;
  assign bus.pd_n     = rst | pd_n_q;

endmodule

// File: tb/tb_pic_cycle_ctrl.sv
module tb_pic_cycle_ctrl;

  typedef enum logic [1:0] {M_FILL, M_RUN, M_FLUSH, M_SLEEP} mstate_t;

  typedef struct packed {
    logic [1:0] q;
    logic       fetch;
    logic       exec;
    logic       nop;
    logic       sleeping;
    logic       wclr;
    logic       wrst;
    logic       to_n;
    logic       pd_n;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  pic_cycle_ctrl_if #(.QW(2)) bus ();

  pic_cycle_ctrl #(.QW(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  obs_t    exp_q[$];
  mstate_t m_st = M_FILL;
  logic [1:0] m_q = 2'd0;
  logic    m_to = 1'b1;
  logic    m_pd = 1'b1;
  logic    got_fetch, got_exec;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs on the falling edge, predict outputs, compare, advance model.
  task automatic step(input logic r, input logic sl, input logic cw,
                      input logic br, input logic sk, input logic tm);
    obs_t e, g;
    mstate_t n_st;
    logic [1:0] n_q;
    logic n_to, n_pd;
    @(negedge clk);
    rst = r;
    bus.sleep_i = sl; bus.clrwdt_i = cw; bus.branch_i = br;
    bus.skip_i = sk;  bus.wdt_tmo = tm;

    e = '0;
    if (r) begin
      e.nop = 1'b1; e.to_n = 1'b1; e.pd_n = 1'b1;
      n_st = M_FILL; n_q = 2'd0; n_to = 1'b1; n_pd = 1'b1;
    end else begin
      e.q = m_q; e.nop = (m_st != M_RUN); e.sleeping = (m_st == M_SLEEP);
      e.to_n = m_to; e.pd_n = m_pd;
      n_st = m_st; n_to = m_to; n_pd = m_pd;
      n_q = (m_st == M_SLEEP) ? 2'd0 : m_q + 2'd1;
      if (tm) begin
        e.wrst = 1'b1;
        n_st = M_FILL; n_q = 2'd0; n_to = 1'b0;
        if (m_st != M_SLEEP) n_pd = 1'b1;
      end else if (m_q == 2'd3 && m_st != M_SLEEP) begin
        e.fetch = 1'b1;
        if (m_st == M_RUN) begin
          e.exec = 1'b1;
          if (br || sk) n_st = M_FLUSH;
          else if (sl) begin e.wclr = 1'b1; n_pd = 1'b0; n_to = 1'b1; n_st = M_SLEEP; end
          else if (cw) begin e.wclr = 1'b1; n_to = 1'b1; n_pd = 1'b1; end
        end else begin
          n_st = M_RUN;
        end
      end
    end
    exp_q.push_back(e);

    #2;
    g = {bus.q, bus.fetch_en, bus.exec_en, bus.nop_sel, bus.sleeping,
         bus.wdt_clr, bus.wdt_rst, bus.to_n, bus.pd_n};
    got_fetch = bus.fetch_en;
    got_exec  = bus.exec_en;
    e = exp_q.pop_front();
    check_eq($sformatf("cyc%0d", cyc), 32'(g), 32'(e));
    cyc++;
    m_st = n_st; m_q = n_q; m_to = n_to; m_pd = n_pd;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Idle until the next RUN Q4, then apply the given decoded inputs there.
  task automatic at_q4(input logic sl, input logic cw, input logic br,
                       input logic sk, input logic tm);
    int k = 0;
    while (!(m_st == M_RUN && m_q == 2'd3) && k < 16) begin
      idle(1);
      k++;
    end
    if (k >= 16) check_eq("q4_wait", 32'(k), 32'd0);
    else step(1'b0, sl, cw, br, sk, tm);
  endtask

  int first_fetch, first_exec, e15, e19, n;

  initial begin
    bus.sleep_i = 0; bus.clrwdt_i = 0; bus.branch_i = 0; bus.skip_i = 0; bus.wdt_tmo = 0;

    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset release: clocks 0..10, branch at clock 11.
    cyc = 0;
    first_fetch = -1; first_exec = -1;
    for (int i = 0; i <= 10; i++) begin
      idle(1);
      if (got_fetch && first_fetch < 0) first_fetch = i;
      if (got_exec && first_exec < 0) first_exec = i;
    end
    check_eq("first_fetch", 32'(first_fetch), 32'd3);
    check_eq("first_exec", 32'(first_exec), 32'd7);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 12; i <= 19; i++) begin
      idle(1);
      if (i == 15) e15 = int'(got_exec);
      if (i == 19) e19 = int'(got_exec);
    end
    check_eq("flush_exec", 32'(e15), 32'd0);
    check_eq("post_flush_exec", 32'(e19), 32'd1);

    // Skip, then sleep together with branch (treated as branch).
    at_q4(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    at_q4(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("br_sleep_no_sleep", 32'(bus.sleeping), 32'd0);

    // SLEEP for 50 clocks, then watchdog wake.
    at_q4(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(50);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    n = 0;
    do begin idle(1); n++; end while (!got_exec && n < 20);
    check_eq("wake_exec_delay", 32'(n), 32'd8);

    // Timeout at q=1 in RUN, then CLRWDT later.
    n = 0;
    while (!(m_st == M_RUN && m_q == 2'd1) && n < 16) begin idle(1); n++; end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(10);
    at_q4(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(2);

    // CLRWDT coinciding with timeout at Q4.
    at_q4(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(6);

    // Reset in SLEEP.
    at_q4(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(3);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(9);

    // Reset in FLUSH.
    at_q4(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(2);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(9);

    // Random mix.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 4) == 0), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 5) == 0), ($urandom_range(0, 39) == 0));
    end

    check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/pic_cycle_ctrl.md
# pic_cycle_ctrl

Instruction-cycle sequencer for the PIC16F54 core. Generates the Q1–Q4 phase count and the per-cycle fetch and commit strobes that the datapath uses to gate W and register-file writes. Inserts a one-cycle NOP flush after taken branches and skips, and sequences SLEEP/watchdog wake-up together with the TO/PD status flags. Sits between Decoder (decoded control inputs), Seqnc/Prog_ROM (fetch) and Reg_File/W (commit).

## Interface
Parameters:
- QW, 2, width of the phase counter; one instruction cycle = 2^QW clocks. The last phase (all ones) is "Q4".

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset; sampled on the rising edge of clk.
- sleep_i  in  1  SLEEP decoded for the instruction in execute.
- clrwdt_i  in  1  CLRWDT decoded for the instruction in execute.
- branch_i  in  1  GOTO, CALL, RETLW or a write to PCL in execute.
- skip_i  in  1  skip condition true for BTFSS/BTFSC/DECFSZ/INCFSZ in execute.
- wdt_tmo  in  1  watchdog overflow; honoured on any clock.
- q  out  QW  current phase, 0..2^QW-1.
- fetch_en  out  1  at Q4: load IR from ROM and advance PC.
- exec_en  out  1  at Q4: commit the executing instruction (gates W_wr, f_wr, stack, PCL).
- nop_sel  out  1  the executing instruction is treated as NOP for the whole cycle.
- sleeping  out  1  core is in SLEEP.
- wdt_clr  out  1  one-clock pulse that clears the watchdog.
- wdt_rst  out  1  one-clock pulse that resets the rest of the core.
- to_n, pd_n  out  1 each  STATUS TO and PD bits, active low.

## Operation
- States: FILL, RUN, FLUSH, SLEEP. Reset state: FILL.
- While rst=1: q=0, state=FILL, to_n=1, pd_n=1, nop_sel=1. fetch_en, exec_en, wdt_clr, wdt_rst and sleeping are all 0.
- q increments by 1 each clock in FILL, RUN and FLUSH, and wraps from 2^QW-1 to 0. In SLEEP, q is held at 0.
- Decoded inputs are sampled only at Q4 in RUN. They are ignored in FILL, FLUSH and SLEEP, and at all other phases.
- fetch_en = (q==Q4) in FILL, RUN or FLUSH, and not wdt_tmo.
- exec_en = (q==Q4) in RUN, and not wdt_tmo.
- nop_sel = 1 whenever state is not RUN.
- FILL: the pipeline is empty. At Q4 it fetches only, then goes to RUN.
- RUN at Q4:
  - If branch_i or skip_i (either or both): commit, then FLUSH for exactly one cycle.
  - Else if sleep_i: commit, pulse wdt_clr, set pd_n=0 and to_n=1, then SLEEP. The next instruction is prefetched at this Q4.
  - Else if clrwdt_i: commit, pulse wdt_clr, set to_n=1 and pd_n=1, stay in RUN.
  - Otherwise: commit and stay in RUN.
- FLUSH: runs one full cycle with nop_sel=1, fetches at Q4, then goes to RUN.
- SLEEP: sleeping=1 and no strobes are issued. Only wdt_tmo or rst leaves this state.
- wdt_tmo=1 on any clock in any state:
  - wdt_rst=1 on that clock; fetch_en and exec_en are forced to 0.
  - Next state is FILL with q=0. to_n is set to 0.
  - pd_n is left unchanged if the timeout occurs in SLEEP (wake, pd_n stays 0). pd_n is set to 1 otherwise.
- Priority: rst > wdt_tmo > branch/skip > sleep > clrwdt.
  - A wdt_tmo that coincides with CLRWDT at Q4 wins: no commit, no wdt_clr.
  - sleep_i together with branch_i is treated as a branch (decoder never produces this; defined for safety).
- wdt_rst does not reset to_n or pd_n; only rst does.

## Timing
- Clock index 0 is the first edge with rst=0.
- After reset release (QW=2): first fetch_en at clock 3, first exec_en at clock 7, then every 4 clocks.
- Single-cycle instruction: one commit per 2^QW clocks.
- Taken branch or skip: exec_en is absent at the following Q4, giving a 2-cycle cost. fetch_en is never skipped outside SLEEP or timeout.
- wdt_clr and wdt_rst are single-clock pulses, combinational from state, q and inputs; they are registered nowhere else.
- to_n and pd_n update on the clock edge that ends the committing Q4 or the timeout clock.
- SLEEP entry: sleeping=1 from the clock after the SLEEP Q4.
- Wake: sleeping=0 from the clock after wdt_tmo. The first exec_en after wake comes 2·2^QW clocks after that edge.
- rst asserted mid-cycle or mid-SLEEP: all outputs take reset values on the next edge.

## Test plan
- Reset release with no inputs active → q = 0,1,2,3,0…; fetch_en at clocks 3, 7, 11; exec_en at 7, 11; nop_sel=1 for clocks 0–3; to_n=pd_n=1.
- branch_i=1 at the Q4 of clock 11 → exec_en=1 at 11, exec_en=0 at 15 with nop_sel=1 for clocks 12–15, exec_en=1 at 19; fetch_en stays at 15 and 19.
- sleep_i=1 at Q4 → exec_en=1 and wdt_clr=1 that clock; then sleeping=1, q frozen at 0, pd_n=0, to_n=1, no strobes for 50 clocks. wdt_tmo=1 → wdt_rst=1, to_n=0, pd_n=0, FILL, next exec_en 8 clocks later.
- wdt_tmo=1 at q=1 in RUN → wdt_rst=1, no exec_en at the following Q4, to_n=0, pd_n=1, restart as after reset. clrwdt_i at a later Q4 → wdt_clr=1, to_n=pd_n=1.
- clrwdt_i=1 and wdt_tmo=1 together at Q4 → exec_en=0, wdt_clr=0, wdt_rst=1, to_n=0.
- rst=1 asserted in SLEEP and in FLUSH → next clock q=0, sleeping=0, to_n=pd_n=1, nop_sel=1, all strobes 0.
